// File: rtl/vga_grid_renderer.sv
// VGA timing generator with a 3-tick pipelined snake/food/border cell renderer.
// Scene inputs are shadowed once per frame at the start of vertical blanking.
module vga_grid_renderer #(
  parameter int H_ACTIVE     = 640,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BP         = 48,
  parameter int V_ACTIVE     = 480,
  parameter int V_FP         = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 33,
  parameter int PIX_DIV      = 2,
  parameter int CELL_SHIFT   = 4,
  parameter int COORD_W      = 6,
  parameter int MAX_LEN      = 64,
  parameter int LEN_W        = 7,
  parameter int FLASH_FRAMES = 30
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [COORD_W-1:0]         food_x,
  input  logic [COORD_W-1:0]         food_y,
  input  logic [MAX_LEN*COORD_W-1:0] snake_x_1dim,
  input  logic [MAX_LEN*COORD_W-1:0] snake_y_1dim,
  input  logic [LEN_W-1:0]           snake_length,
  input  logic [1:0]                 game_state,
  output logic [3:0]                 r,
  output logic [3:0]                 g,
  output logic [3:0]                 b,
  output logic                       h_sync,
  output logic                       v_sync,
  output logic                       frame_tick
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int DW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam int FW = $clog2(FLASH_FRAMES + 1);
  localparam int COLS = H_ACTIVE >> CELL_SHIFT;
  localparam int ROWS = V_ACTIVE >> CELL_SHIFT;
  localparam int SW = MAX_LEN * COORD_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_PLAY  = 2'b01,
    ST_OVER  = 2'b10,
    ST_PAUSE = 2'b11
  } mode_t;

  logic [DW-1:0] div;
  logic          tick;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          capture;
  mode_t         in_mode;

  assign tick    = (div == DW'(PIX_DIV - 1));
  assign capture = tick && (h_cnt == '0) && (v_cnt == VW'(V_ACTIVE));
  assign frame_tick = capture;
  assign in_mode = mode_t'(game_state);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       div <= '0;
    else if (tick) div <= '0;
    else           div <= div + DW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (tick) begin
      if (h_cnt == HW'(H_TOTAL - 1)) begin
        h_cnt <= '0;
        if (v_cnt == VW'(V_TOTAL - 1)) v_cnt <= '0;
        else                           v_cnt <= v_cnt + VW'(1);
      end else begin
        h_cnt <= h_cnt + HW'(1);
      end
    end
  end

  logic [COORD_W-1:0] sh_fx, sh_fy;
  logic [SW-1:0]      sh_sx, sh_sy;
  logic [LEN_W-1:0]   sh_len;
  mode_t              sh_mode;
  logic [FW-1:0]      fl_cnt;
  logic               fl_off;

  // Flash phase restarts on entry to game over; held clear elsewhere.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_fx   <= '0;
      sh_fy   <= '0;
      sh_sx   <= '0;
      sh_sy   <= '0;
      sh_len  <= '0;
      sh_mode <= ST_IDLE;
      fl_cnt  <= '0;
      fl_off  <= 1'b0;
    end else if (capture) begin
      sh_fx   <= food_x;
      sh_fy   <= food_y;
      sh_sx   <= snake_x_1dim;
      sh_sy   <= snake_y_1dim;
      sh_len  <= snake_length;
      sh_mode <= in_mode;
      if (in_mode != ST_OVER || sh_mode != ST_OVER) begin
        fl_cnt <= '0;
        fl_off <= 1'b0;
      end else if (fl_cnt == FW'(FLASH_FRAMES - 1)) begin
        fl_cnt <= '0;
        fl_off <= ~fl_off;
      end else begin
        fl_cnt <= fl_cnt + FW'(1);
      end
    end
  end

  logic               hs_raw, vs_raw, act_raw;
  logic [COORD_W-1:0] s1_cx, s1_cy;
  logic               s1_act, s1_hs, s1_vs;

  assign hs_raw = !((h_cnt >= HW'(H_ACTIVE + H_FP)) &&
                    (h_cnt <  HW'(H_ACTIVE + H_FP + H_SYNC)));
  assign vs_raw = !((v_cnt >= VW'(V_ACTIVE + V_FP)) &&
                    (v_cnt <  VW'(V_ACTIVE + V_FP + V_SYNC)));
  assign act_raw = (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_cx  <= '0;
      s1_cy  <= '0;
      s1_act <= 1'b0;
      s1_hs  <= 1'b1;
      s1_vs  <= 1'b1;
    end else if (tick) begin
      s1_cx  <= COORD_W'(h_cnt >> CELL_SHIFT);
      s1_cy  <= COORD_W'(v_cnt >> CELL_SHIFT);
      s1_act <= act_raw;
      s1_hs  <= hs_raw;
      s1_vs  <= vs_raw;
    end
  end

  logic head_hit, body_hit, food_hit, bord_hit;
  logic s2_head, s2_body, s2_food, s2_bord;
  logic s2_act, s2_hs, s2_vs;

  // Segments at or beyond the shadowed length never match.
  always_comb begin
    head_hit = 1'b0;
    body_hit = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (i < int'(sh_len) &&
          sh_sx[i*COORD_W +: COORD_W] == s1_cx &&
          sh_sy[i*COORD_W +: COORD_W] == s1_cy) begin
        if (i == 0) head_hit = 1'b1;
        else        body_hit = 1'b1;
      end
    end
  end

  assign food_hit = (sh_fx == s1_cx) && (sh_fy == s1_cy);
  assign bord_hit = (s1_cx == '0) || (s1_cx == COORD_W'(COLS - 1)) ||
                    (s1_cy == '0) || (s1_cy == COORD_W'(ROWS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_head <= 1'b0;
      s2_body <= 1'b0;
      s2_food <= 1'b0;
      s2_bord <= 1'b0;
      s2_act  <= 1'b0;
      s2_hs   <= 1'b1;
      s2_vs   <= 1'b1;
    end else if (tick) begin
      s2_head <= head_hit;
      s2_body <= body_hit;
      s2_food <= food_hit;
      s2_bord <= bord_hit;
      s2_act  <= s1_act;
      s2_hs   <= s1_hs;
      s2_vs   <= s1_vs;
    end
  end

  logic [11:0] base, pix;

  always_comb begin
    base = 12'h000;
    if (s2_head)      base = 12'hFF0;
    else if (s2_body) base = 12'h0F0;
    else if (s2_food) base = 12'hF00;
    else if (s2_bord) base = 12'h888;
    pix = base;
    case (sh_mode)
      ST_IDLE:  pix = s2_bord ? 12'h888 : 12'h000;
      ST_PAUSE: pix = {1'b0, base[11:9], 1'b0, base[7:5], 1'b0, base[3:1]};
      ST_OVER:  if (!fl_off && (s2_head || s2_body)) pix = 12'hF00;
      default:  pix = base;
    endcase
    if (!s2_act) pix = 12'h000;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r      <= '0;
      g      <= '0;
      b      <= '0;
      h_sync <= 1'b1;
      v_sync <= 1'b1;
    end else if (tick) begin
      {r, g, b} <= pix;
      h_sync    <= s2_hs;
      v_sync    <= s2_vs;
    end
  end
endmodule
